instr_fetch_mem: RTL and testbench
==================================

# instr_fetch_mem

Instruction memory and fetch responder for the 16-bit datapath. Accepts a program as a stream of 16-bit words over a valid/ready load port, then answers the datapath's `PC` with the addressed instruction one clock later. While loading, `run` is held low to stall the datapath. Out-of-range fetches return a NOP and raise a sticky fault.

## Interface
Parameters:
- `ADDR_W`, 8: PC / memory address width.
- `DATA_W`, 16: instruction width.
- `NOP_INSTR`, 16'h0000: word returned on an out-of-range fetch.

Ports:
- `_CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  a program word is presented.
- `load_ready`  out  1  block accepts a load word this cycle.
- `load_data`  in  DATA_W  program word.
- `load_last`  in  1  marks the final program word.
- `reload`  in  1  one-cycle request to discard the program and reload.
- `PC`  in  ADDR_W  fetch address from the datapath.
- `instruction`  out  DATA_W  fetched instruction, registered.
- `run`  out  1  program loaded; datapath may execute.
- `prog_len`  out  ADDR_W+1  number of words loaded (0..256).
- `fault`  out  1  sticky: a fetch hit `PC >= prog_len` while in RUN.

## Operation
- FSM states: EMPTY, LOAD, RUN.
  - EMPTY → LOAD on the first accepted word.
  - LOAD → RUN when the word carrying `load_last` is accepted.
  - RUN → EMPTY on `reload`.
  - EMPTY → RUN directly when the first accepted word also has `load_last`.
- `load_ready` is 1 in EMPTY and LOAD and 0 in RUN. It is decoded from state only and is not a function of `load_valid`.
- A word is accepted when `load_valid && load_ready`:
  - `mem[wr_ptr] <= load_data`, then `wr_ptr` and `prog_len` are incremented.
- Address wrap: when the word at address 2^ADDR_W−1 is accepted, it is treated as last even if `load_last` = 0. The FSM moves to RUN with `prog_len` = 256. `wr_ptr` never wraps to overwrite address 0.
- Entering EMPTY, whether by reset or by `reload`, clears `wr_ptr`, `prog_len`, `fault` and `instruction`. Memory contents are not cleared.
- Fetch, evaluated in RUN only:
  - `PC < prog_len`: `instruction <= mem[PC]`.
  - Otherwise: `instruction <= NOP_INSTR` and `fault <= 1`. The fault stays set until reset or `reload`.
- In EMPTY and LOAD, `instruction` is held at `NOP_INSTR`.
- `reload` asserted in EMPTY or LOAD is ignored. The load in progress continues.
- If `reload` and `load_valid` are both high in RUN, the word is not accepted, because `load_ready` is 0 that cycle.

## Timing
- Reset values (asynchronous):
  - state = EMPTY
  - `load_ready` = 1
  - `run` = 0
  - `prog_len` = 0
  - `fault` = 0
  - `instruction` = `NOP_INSTR`
- Load throughput is one word per clock. No bubble occurs between consecutive accepted words.
- `run` rises on the edge that accepts the last word. `load_ready` falls on the same edge.
- Fetch latency is 1 clock: `PC` is sampled at edge N and `instruction` is valid after edge N.
  - The first fetch is performed at the edge after `run` rises, using the `PC` present at that edge.
- `fault` is set at the same edge that drives the out-of-range NOP.
- `reload` at edge N: after edge N, `run` = 0, `load_ready` = 1 and `prog_len` = 0. A word can be accepted at edge N+1.
- Asserting RESET mid-load abandons the partial program immediately, without waiting for a clock.

## Structure
- Package `imem_pkg`:
  - state enum (EMPTY/LOAD/RUN)
  - `ADDR_W`/`DATA_W` defaults
  - `NOP_INSTR`
- Sub-module `imem_ram`: 2^ADDR_W × DATA_W array with a synchronous write port and a synchronous registered read port. It has no reset.
- The top level holds the FSM, `wr_ptr`, `prog_len`, the range compare and the fault/NOP mux. The mux selects the output of the registered read.

## Test plan
- Reset, then load 6 words with `load_last` on the 6th: 0000, 0400, 800D, 8407, 4FFF, 03AB. Required: `prog_len` = 6; `run` = 1 and `load_ready` = 0 on the edge that accepts 03AB.
- In RUN, drive `PC` = 0,1,2,3,4,5 on successive edges. Required: `instruction` = 0000, 0400, 800D, 8407, 4FFF, 03AB, each one edge after its `PC`; `fault` = 0.
- In RUN, drive `PC` = 6. Required: `instruction` = 0000 and `fault` = 1 after that edge. Then drive `PC` = 2. Required: `instruction` = 800D and `fault` stays 1.
- Load 256 words (value = address) with `load_last` never set and `load_valid` dropped for 3 cycles mid-stream. Required: `prog_len` = 256 and `run` = 1 after the 256th word; `PC` = FF → `instruction` = 00FF.
- Load 3 of 5 words, then assert RESET between clock edges. Required: `run` = 0, `prog_len` = 0 and `load_ready` = 1 immediately, before the next edge. A fresh 2-word load then reaches RUN.
- In RUN, pulse `reload` together with `load_valid` = 1. Required: the word is not accepted; afterwards `run` = 0, `prog_len` = 0, `fault` = 0; a new 1-word load with `load_last` reaches RUN in one edge.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction memory / fetch responder.
package imem_pkg;

    localparam int unsigned IMEM_ADDR_W = 8;
    localparam int unsigned IMEM_DATA_W = 16;
    localparam logic [15:0] IMEM_NOP    = 16'h0000;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-clock program RAM: synchronous write, registered read, no reset.
module imem_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              _CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge _CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with valid/ready program load port and one-cycle fetch
// responder; out-of-range fetches return NOP_INSTR and set a sticky fault.
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int unsigned         ADDR_W    = IMEM_ADDR_W,
    parameter int unsigned         DATA_W    = IMEM_DATA_W,
    parameter logic [DATA_W-1:0]   NOP_INSTR = DATA_W'(IMEM_NOP)
) (
    input  logic              _CLK,
    input  logic              RESET,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              reload,
    input  logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] instruction,
    output logic              run,
    output logic [ADDR_W:0]   prog_len,
    output logic              fault
);

    imem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              accept;
    logic              last_word;
    logic              in_range;
    logic              fetch_hit;

    assign load_ready = (state_q != S_RUN);
    assign run        = (state_q == S_RUN);
    assign accept     = load_valid && load_ready;
    // The top address closes the program even without load_last.
    assign last_word  = load_last || (wr_ptr == '1);
    assign in_range   = {1'b0, PC} < prog_len;

    always_ff @(posedge _CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (accept) state_d = last_word ? S_RUN : S_LOAD;
            S_LOAD:  if (accept && last_word) state_d = S_RUN;
            S_RUN:   if (reload) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge _CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr    <= '0;
            prog_len  <= '0;
            fault     <= 1'b0;
            fetch_hit <= 1'b0;
        end else if (state_q == S_RUN) begin
            if (reload) begin
                wr_ptr    <= '0;
                prog_len  <= '0;
                fault     <= 1'b0;
                fetch_hit <= 1'b0;
            end else begin
                fetch_hit <= in_range;
                if (!in_range) begin
                    fault <= 1'b1;
                end
            end
        end else begin
            fetch_hit <= 1'b0;
            if (accept) begin
                prog_len <= prog_len + (ADDR_W + 1)'(1);
                if (wr_ptr != '1) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
            end
        end
    end

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        ._CLK  (_CLK),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (load_data),
        .raddr (PC),
        .rdata (rd_data)
    );

    // RAM read data is already registered; the hit flag gates it so that
    // reset and reload force NOP without touching the array.
    assign instruction = fetch_hit ? rd_data : NOP_INSTR;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: table-driven load/fetch vectors
// plus hand-written wrap, mid-load reset and reload sequences.
module tb_instr_fetch_mem;

    logic        clk;
    logic        RESET;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        load_last;
    logic        reload;
    logic [7:0]  PC;
    logic [15:0] instruction;
    logic        run;
    logic [8:0]  prog_len;
    logic        fault;

    int tests;
    int fails;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
        logic        flt;
    } fetch_vec_t;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } load_vec_t;

    fetch_vec_t sb_q[$];
    load_vec_t  load_tbl[6];
    fetch_vec_t fetch_tbl[8];

    instr_fetch_mem #(
        .ADDR_W    (8),
        .DATA_W    (16),
        .NOP_INSTR (16'h0000)
    ) dut (
        ._CLK        (clk),
        .RESET       (RESET),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .reload      (reload),
        .PC          (PC),
        .instruction (instruction),
        .run         (run),
        .prog_len    (prog_len),
        .fault       (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] pc, input logic [15:0] ei, input logic ef);
        fetch_vec_t e;
        PC = pc;
        sb_q.push_back('{pc: pc, instr: ei, flt: ef});
        step();
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("instr_pc%02h", e.pc), 32'(instruction), 32'(e.instr));
            check($sformatf("fault_pc%02h", e.pc), 32'(fault), 32'(e.flt));
        end
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_run"},        32'(run),         32'd0);
        check({tag, "_load_ready"}, 32'(load_ready),  32'd1);
        check({tag, "_prog_len"},   32'(prog_len),    32'd0);
        check({tag, "_fault"},      32'(fault),       32'd0);
        check({tag, "_instr"},      32'(instruction), 32'h0000);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        RESET      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        reload     = 1'b0;
        PC         = '0;

        load_tbl = '{'{16'h0000, 1'b0}, '{16'h0400, 1'b0}, '{16'h800D, 1'b0},
                     '{16'h8407, 1'b0}, '{16'h4FFF, 1'b0}, '{16'h03AB, 1'b1}};
        fetch_tbl = '{'{8'd0, 16'h0000, 1'b0}, '{8'd1, 16'h0400, 1'b0},
                      '{8'd2, 16'h800D, 1'b0}, '{8'd3, 16'h8407, 1'b0},
                      '{8'd4, 16'h4FFF, 1'b0}, '{8'd5, 16'h03AB, 1'b0},
                      '{8'd6, 16'h0000, 1'b1}, '{8'd2, 16'h800D, 1'b1}};

        #12;
        check_empty("reset");
        RESET = 1'b0;

        // 6-word program
        for (int unsigned i = 0; i < 6; i++) begin
            load_word(load_tbl[i].data, load_tbl[i].last);
            check($sformatf("load%0d_prog_len", i), 32'(prog_len), i + 1);
            check($sformatf("load%0d_run", i),      32'(run),        (i == 5) ? 32'd1 : 32'd0);
            check($sformatf("load%0d_ready", i),    32'(load_ready), (i == 5) ? 32'd0 : 32'd1);
        end

        for (int unsigned i = 0; i < 8; i++) begin
            fetch(fetch_tbl[i].pc, fetch_tbl[i].instr, fetch_tbl[i].flt);
        end

        // reload clears fault, then 256-word load with a gap and no load_last
        reload = 1'b1;
        step();
        reload = 1'b0;
        check_empty("reload1");

        for (int unsigned i = 0; i < 256; i++) begin
            if (i == 100) begin
                for (int unsigned g = 0; g < 3; g++) begin
                    step();
                    check("gap_prog_len", 32'(prog_len), 32'd100);
                end
            end
            load_word(16'(i), 1'b0);
            if (i == 254) begin
                check("wrap254_run", 32'(run), 32'd0);
                check("wrap254_len", 32'(prog_len), 32'd255);
            end
        end
        check("wrap_prog_len", 32'(prog_len),   32'd256);
        check("wrap_run",      32'(run),        32'd1);
        check("wrap_ready",    32'(load_ready), 32'd0);

        load_word(16'hBEEF, 1'b1);
        check("run_noaccept_len", 32'(prog_len), 32'd256);
        fetch(8'hFF, 16'h00FF, 1'b0);
        fetch(8'h00, 16'h0000, 1'b0);
        fetch(8'h80, 16'h0080, 1'b0);

        // mid-load asynchronous reset
        reload = 1'b1;
        step();
        reload = 1'b0;
        load_word(16'h1111, 1'b0);
        load_word(16'h2222, 1'b0);
        load_word(16'h3333, 1'b0);
        check("partial_len", 32'(prog_len), 32'd3);
        #3;
        RESET = 1'b1;
        #1;
        check_empty("async_reset");
        #1;
        RESET = 1'b0;

        load_word(16'h1234, 1'b0);
        reload = 1'b1;
        step();
        reload = 1'b0;
        check("reload_in_load_len",   32'(prog_len),   32'd1);
        check("reload_in_load_ready", 32'(load_ready), 32'd1);
        load_word(16'h5678, 1'b1);
        check("fresh_run", 32'(run),      32'd1);
        check("fresh_len", 32'(prog_len), 32'd2);
        fetch(8'd1, 16'h5678, 1'b0);
        fetch(8'd2, 16'h0000, 1'b1);

        // reload together with load_valid in RUN
        reload     = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        load_last  = 1'b1;
        step();
        reload     = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        check_empty("reload2");

        load_word(16'hABCD, 1'b1);
        check("one_word_run", 32'(run),      32'd1);
        check("one_word_len", 32'(prog_len), 32'd1);
        fetch(8'd0, 16'hABCD, 1'b0);
        fetch(8'd1, 16'h0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
